// File: rtl/fc_64_axil_regs.sv
// AXI4-Lite register file for FC_64: CTRL/STATUS/DATA_IN/RESULT, start pulse out, done/result capture in.
// Latency: AW+W -> B handshake 3 cycles, AR -> R handshake 3 cycles; fc_start one cycle after the write edge.
// Backpressure: one write and one read in flight; no new acceptance while BVALID or RVALID waits for its READY.
module fc_64_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              fc_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     fc_data,
    input  logic                              fc_busy,
    input  logic                              fc_done,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     fc_result,
    output logic                              irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    logic [31:0] ctrl_q;
    logic [31:0] data_in_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        err_q;
    logic        fc_start_q;

    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic        wr_en;
    logic        rd_en;
    logic [1:0]  wr_sel;
    logic [1:0]  rd_sel;
    logic [31:0] wr_mask;
    logic [31:0] ctrl_nxt;
    logic [31:0] data_in_nxt;
    logic [31:0] rd_mux;
    logic        start_req;
    logic        done_clr;
    logic        err_clr;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_sel = S_AXI_AWADDR[3:2];
    assign rd_sel = S_AXI_ARADDR[3:2];
    assign wr_en  = awready_q & wready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en  = arready_q & S_AXI_ARVALID;

    // Start and W1C side effects live in byte 0, so they need its strobe.
    assign start_req = wr_en & (wr_sel == REG_CTRL)   & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
    assign done_clr  = wr_en & (wr_sel == REG_STATUS) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
    assign err_clr   = wr_en & (wr_sel == REG_STATUS) & S_AXI_WSTRB[0] & S_AXI_WDATA[2];

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < 4; b++) begin
            wr_mask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
        end
        ctrl_nxt    = ((ctrl_q & ~wr_mask) | (S_AXI_WDATA & wr_mask)) & 32'hFFFF_FFFE;
        data_in_nxt = (data_in_q & ~wr_mask) | (S_AXI_WDATA & wr_mask);
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            REG_CTRL:   rd_mux = ctrl_q;
            REG_STATUS: rd_mux = {29'b0, err_q, done_q, fc_busy};
            REG_DATA:   rd_mux = data_in_q;
            REG_RESULT: rd_mux = result_q;
            default:    rd_mux = '0;
        endcase
    end

    // Write channel: AW and W are only ever accepted together.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
            wready_q  <= S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= S_AXI_ARVALID & ~arready_q & ~rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q     <= '0;
            data_in_q  <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fc_start_q <= 1'b0;
        end else begin
            if (wr_en && wr_sel == REG_CTRL) begin
                ctrl_q <= ctrl_nxt;
            end
            if (wr_en && wr_sel == REG_DATA) begin
                data_in_q <= data_in_nxt;
            end
            if (fc_done) begin
                result_q <= fc_result;
            end
            // A same-edge set beats the clear.
            done_q     <= fc_done | (done_q & ~done_clr);
            err_q      <= (start_req & fc_busy) | (err_q & ~err_clr);
            fc_start_q <= start_req & ~fc_busy;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign fc_start      = fc_start_q;
    assign fc_data       = data_in_q;
    assign irq           = ctrl_q[1] & done_q;

endmodule

// File: doc/fc_64_axil_regs.md
# fc_64_axil_regs

AXI4-Lite slave register file for the FC_64 fully-connected accelerator IP. It is the responder for the AXI4-Lite write and read bursts issued by the processor or the VIP master in the block-design bench. It exposes control, status, input-operand and result registers. It converts register writes into a single-cycle start pulse toward the FC_64 datapath and captures the datapath's completion and result.

## Interface

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: AXI address width. Bits [3:2] select the register; bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1: the block's single clock.
- S_AXI_ARESETN  in  1: asynchronous, active-low reset.
- S_AXI_AWADDR  in  4 / S_AXI_AWPROT  in  3 (ignored) / S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  4 / S_AXI_ARPROT  in  3 (ignored) / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- fc_start  out  1: one-cycle start pulse to the FC_64 core.
- fc_data  out  32: operand word, equal to the DATA_IN register.
- fc_busy  in  1: the core is computing.
- fc_done  in  1: one-cycle completion pulse from the core.
- fc_result  in  32: core result, valid in the cycle fc_done is high.
- irq  out  1: level interrupt, equal to CTRL.irq_en AND STATUS.done.

## Operation

Register map:
- 0x0 CTRL (read/write).
  - Bit 0 is start. It is write-1-to-trigger, always reads 0, and is never stored.
  - Bit 1 is irq_en, stored.
  - Bits 31:2 are stored scratch.
- 0x4 STATUS (bits 31:3 read 0).
  - Bit 0 is busy: read-only mirror of fc_busy.
  - Bit 1 is done: sticky, write-1-to-clear.
  - Bit 2 is err: sticky, write-1-to-clear.
- 0x8 DATA_IN: read/write, with byte strobes honoured.
- 0xC RESULT: read-only. Loaded from fc_result when fc_done=1. Writes are discarded but still respond OKAY.

Write path:
- WSTRB masks bytes on CTRL bits 31:1 and on DATA_IN.
- The W1C and start actions only act when WSTRB[0]=1.

Start:
- A write to CTRL with WDATA[0]=1 and fc_busy=0 produces fc_start=1 in the cycle after the write edge.
- The same write with fc_busy=1 produces no pulse and sets STATUS.err instead.

Done, err and result:
- An fc_done pulse sets STATUS.done and loads RESULT.
- If fc_done and a W1C of done land on the same edge, set wins: done stays 1.
- The same set-wins rule applies to err.

Responses:
- BRESP and RRESP are always 2'b00 (OKAY).

## Timing

Reset values: every output is 0 while S_AXI_ARESETN=0. This covers AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, BRESP, RRESP, fc_start, fc_data and irq. Every register also resets to 0.

Write channel:
- In a cycle where AWVALID=1, WVALID=1, AWREADY=0 and BVALID=0, AWREADY and WREADY both go 1 for exactly the next cycle.
- The address and data are accepted on that edge and the register is updated on the same edge.
- BVALID goes 1 on the following cycle and holds until BREADY=1.
- A new address/data acceptance never occurs while BVALID=1.
- AW arriving without W, or W without AW, waits; there is no partial acceptance.

Read channel:
- In a cycle where ARVALID=1, ARREADY=0 and RVALID=0, ARREADY goes 1 for one cycle and the address is latched.
- RVALID and RDATA appear in the next cycle.
- RDATA is sampled from the register state at the latch edge.
- RVALID and RDATA hold stable until RREADY=1.

Latency with VALID and READY held high by the master:
- Write: 3 cycles from AWVALID/WVALID to B handshake.
- Read: 3 cycles from ARVALID to R handshake.

Read and write channels operate concurrently and independently. If a read and a write target the same register in the same edge, the read returns the pre-write value.

fc_start is exactly one cycle wide. Back-to-back start writes produce separate pulses, because each write takes at least 3 cycles.

Reset asserted mid-transaction drops all VALID/READY signals immediately and discards the transaction. Recovery is clean from the first edge after deassertion.

## Test plan

- Reset check: hold ARESETN low for 200 ns -> all outputs are 0. Then read all four registers -> 0x0, 0x0 (with fc_busy=0), 0x0, 0x0.
- Write and read back: write DATA_IN=0x0000_0003 and CTRL=0x0000_0006 -> reads return 0x3 and 0x6 (start bit reads 0), and fc_data=0x3. Write RESULT=0x4 -> OKAY response, and RESULT still reads 0.
- Byte strobes: DATA_IN=0x1122_3344, then write 0xAABB_CCDD with WSTRB=4'b0101 -> DATA_IN reads 0x11BB_33DD.
- Start handshake:
  - Write CTRL=0x3 with fc_busy=0 -> exactly one fc_start pulse.
  - Drive fc_done with fc_result=0xDEAD_BEEF -> STATUS=0x2, RESULT=0xDEAD_BEEF, irq=1.
  - Write STATUS=0x2 -> STATUS=0x0 and irq=0.
- Busy collision and race: write CTRL=0x1 with fc_busy=1 -> no fc_start, STATUS=0x5. Align fc_done with a W1C write of 0x2 on the same edge -> done remains 1.
- Backpressure and reset: hold BREADY=0 for 10 cycles -> BVALID is held and no second AWREADY occurs. Assert ARESETN low while RVALID=1 with RREADY=0 -> RVALID drops to 0 immediately.
